// File: rtl/serial_byte_rx_if.sv
// ---------------------------------------------------------------------------
// serial_byte_rx_if
// Parallel output handshake of the serial byte receiver.
//   data_out   : assembled word, stable while data_valid=1
//   data_valid : data_out holds an unconsumed word
//   data_ready : consumer takes the word when data_valid && data_ready
// Modports:
//   master : the receiver (drives data_out/data_valid, reads data_ready)
//   slave  : the consumer (reads data_out/data_valid, drives data_ready)
// ---------------------------------------------------------------------------
interface serial_byte_rx_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             data_ready;

    modport master (
        output data_out,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  data_out,
        input  data_valid,
        output data_ready
    );
endinterface

// File: rtl/serial_byte_rx.sv
// ---------------------------------------------------------------------------
// serial_byte_rx
// Serial-to-parallel receiver for framed words on a single-bit line
// (start bit 0, WIDTH data bits, stop bit 1, idle level 1). The line is
// sampled only on cycles with bit_en=1. A good frame is presented on a
// one-entry valid/ready holding register.
//
// Parameters:
//   WIDTH     : data bits per frame (2..16)
//   MSB_FIRST : 1 = first data bit lands in data_out[WIDTH-1], 0 = in bit 0
//
// Ports:
//   clk       : system clock, rising edge
//   rst_n     : synchronous active-low reset
//   sin       : serial line
//   bit_en    : bit strobe, sin sampled only when 1
//   out_if    : master side of serial_byte_rx_if (data_out/valid/ready)
//   frame_err : one-cycle pulse, stop bit sampled as 0
//   overrun   : one-cycle pulse, good frame dropped because the holding
//               register was full and not being drained
//   busy      : receiver is not in IDLE
//   parity_err: (RX_PARITY_EN only) one-cycle pulse, even-parity failure
//
// Optional feature macro: RX_PARITY_EN adds an even-parity bit between the
// last data bit and the stop bit, plus the parity_err output.
// ---------------------------------------------------------------------------
module serial_byte_rx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sin,
    input  logic              bit_en,
    serial_byte_rx_if.master  out_if,
    output logic              frame_err,
    output logic              overrun,
`ifdef RX_PARITY_EN
    output logic              parity_err,
`endif
    output logic              busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

`ifdef RX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DATA   = 3'd1,
        PARITY = 3'd2,
        STOP   = 3'd3,
        BREAK  = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DATA   = 3'd1,
        STOP   = 3'd3,
        BREAK  = 3'd4
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;
    logic             frame_good;
`ifdef RX_PARITY_EN
    logic             par_q, par_d;
    logic             perr_q, perr_d;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
`ifdef RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        data_d     = data_q;
        valid_d    = valid_q;
        ferr_d     = 1'b0;
        ovr_d      = 1'b0;
        frame_good = 1'b0;
`ifdef RX_PARITY_EN
        par_d      = par_q;
        perr_d     = 1'b0;
`endif

        // Consumer handshake runs every cycle, independent of the strobe.
        if (valid_q && out_if.data_ready) begin
            valid_d = 1'b0;
        end

        if (bit_en) begin
            unique case (state_q)
                IDLE: begin
                    if (!sin) begin
                        state_d = DATA;
                        cnt_d   = '0;
                    end
                end
                DATA: begin
                    if (MSB_FIRST) begin
                        shift_d = {shift_q[WIDTH-2:0], sin};
                    end else begin
                        shift_d = {sin, shift_q[WIDTH-1:1]};
                    end
                    if (cnt_q == LAST_BIT) begin
                        cnt_d   = '0;
`ifdef RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`ifdef RX_PARITY_EN
                PARITY: begin
                    par_d   = sin;
                    state_d = STOP;
                end
`endif
                STOP: begin
                    if (!sin) begin
                        // Stop-bit error wins over any parity result.
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end else begin
                        state_d = IDLE;
`ifdef RX_PARITY_EN
                        if (^{shift_q, par_q}) begin
                            perr_d = 1'b1;
                        end else begin
                            frame_good = 1'b1;
                        end
`else
                        frame_good = 1'b1;
`endif
                    end
                end
                BREAK: begin
                    // A held-low line must not look like a new start bit.
                    if (sin) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // A load may coincide with a consume: the new word replaces the old
        // one and valid stays set.
        if (frame_good) begin
            if (!valid_q || out_if.data_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    assign out_if.data_out   = data_q;
    assign out_if.data_valid = valid_q;
    assign frame_err         = ferr_q;
    assign overrun           = ovr_q;
    assign busy              = (state_q != IDLE);
`ifdef RX_PARITY_EN
    assign parity_err        = perr_q;
`endif

endmodule

// File: tb/tb_serial_byte_rx.sv
// ---------------------------------------------------------------------------
// tb_serial_byte_rx
// Directed bench for serial_byte_rx (WIDTH=8, MSB_FIRST=1). Each scenario is
// a task with its own inline checks against hand-computed values.
// Build with +define+RX_PARITY_EN to exercise the parity variant.
// ---------------------------------------------------------------------------
module tb_serial_byte_rx;

    logic clk = 1'b0;
    logic rst_n;
    logic sin;
    logic bit_en;
    logic frame_err;
    logic overrun;
    logic busy;
`ifdef RX_PARITY_EN
    logic parity_err;
`endif

    int total = 0;
    int bad   = 0;

    serial_byte_rx_if #(.WIDTH(8)) bus ();

    serial_byte_rx #(
        .WIDTH     (8),
        .MSB_FIRST (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sin       (sin),
        .bit_en    (bit_en),
        .out_if    (bus.master),
        .frame_err (frame_err),
        .overrun   (overrun),
`ifdef RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // One clock with the given line value and strobe asserted; returns 1 ns
    // after the edge with the strobe dropped.
    task automatic strobe(input logic b);
        sin    = b;
        bit_en = 1'b1;
        @(posedge clk);
        #1;
        bit_en = 1'b0;
    endtask

    task automatic idle_clk();
        bit_en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Start bit, 8 data bits MSB first, optional parity, stop bit. Returns
    // just after the edge that sampled the stop bit. gap inserts one
    // bit_en=0 clock after every strobe except the stop bit.
    task automatic send_frame(input logic [7:0] d, input logic p,
                              input logic stop, input logic gap);
        strobe(1'b0);
        if (gap) idle_clk();
        for (int i = 7; i >= 0; i--) begin
            strobe(d[i]);
            if (gap) idle_clk();
        end
`ifdef RX_PARITY_EN
        strobe(p);
        if (gap) idle_clk();
`else
        if (p) begin end
`endif
        strobe(stop);
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        bit_en         = 1'b1;
        sin            = 1'b1;
        bus.data_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus.data_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.data_valid); end
        total++; if (bus.data_out !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", bus.data_out); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b exp=0", frame_err); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_ovr got=%b exp=0", overrun); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
`ifdef RX_PARITY_EN
        total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL reset_perr got=%b exp=0", parity_err); end
`endif
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            strobe(1'b1);
            total++;
            if ({busy, frame_err, overrun, bus.data_valid} !== 4'b0000) begin
                bad++;
                $display("FAIL idle_line strobe=%0d got=%b exp=0000", i,
                         {busy, frame_err, overrun, bus.data_valid});
            end
        end
    endtask

    task automatic test_basic_frame();
        bus.data_ready = 1'b1;
        send_frame(8'h90, 1'b0, 1'b1, 1'b0);
        total++; if (bus.data_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", bus.data_valid); end
        total++; if (bus.data_out !== 8'h90) begin bad++; $display("FAIL basic_data got=%h exp=90", bus.data_out); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy got=%b exp=0", busy); end
        idle_clk();
        total++; if (bus.data_valid !== 1'b0) begin bad++; $display("FAIL basic_consumed got=%b exp=0", bus.data_valid); end
    endtask

    task automatic test_bit_en_gaps();
        bus.data_ready = 1'b1;
        // Partial frame: start + 3 bits with gaps, state must hold.
        strobe(1'b0);
        idle_clk();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL gap_busy_hold got=%b exp=1", busy); end
        strobe(1'b1); idle_clk();
        strobe(1'b0); idle_clk();
        strobe(1'b0); idle_clk();
        repeat (3) idle_clk();
        strobe(1'b1); idle_clk();
        strobe(1'b0); idle_clk();
        strobe(1'b0); idle_clk();
        strobe(1'b0); idle_clk();
        strobe(1'b0); idle_clk();
        total++; if (bus.data_valid !== 1'b0) begin bad++; $display("FAIL gap_early_valid got=%b exp=0", bus.data_valid); end
        strobe(1'b1);
        total++; if (bus.data_valid !== 1'b1) begin bad++; $display("FAIL gap_valid got=%b exp=1", bus.data_valid); end
        total++; if (bus.data_out !== 8'h90) begin bad++; $display("FAIL gap_data got=%h exp=90", bus.data_out); end
        idle_clk();
        total++; if (bus.data_valid !== 1'b0) begin bad++; $display("FAIL gap_consumed got=%b exp=0", bus.data_valid); end
        // Whole frame through the helper with gaps as well.
        send_frame(8'h3A, ^8'h3A, 1'b1, 1'b1);
        total++; if (bus.data_out !== 8'h3A) begin bad++; $display("FAIL gap_frame2 got=%h exp=3a", bus.data_out); end
        idle_clk();
    endtask

    task automatic test_overrun();
        bus.data_ready = 1'b0;
        send_frame(8'h11, ^8'h11, 1'b1, 1'b0);
        total++; if (bus.data_out !== 8'h11) begin bad++; $display("FAIL ovr_first got=%h exp=11", bus.data_out); end
        idle_clk();
        idle_clk();
        total++; if (bus.data_valid !== 1'b1) begin bad++; $display("FAIL ovr_held got=%b exp=1", bus.data_valid); end
        send_frame(8'h62, ^8'h62, 1'b1, 1'b0);
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_pulse got=%b exp=1", overrun); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL ovr_no_ferr got=%b exp=0", frame_err); end
        total++; if (bus.data_out !== 8'h11) begin bad++; $display("FAIL ovr_data_kept got=%h exp=11", bus.data_out); end
        idle_clk();
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_one_cycle got=%b exp=0", overrun); end
        bus.data_ready = 1'b1;
        idle_clk();
        total++; if (bus.data_valid !== 1'b0) begin bad++; $display("FAIL ovr_drain got=%b exp=0", bus.data_valid); end
    endtask

    task automatic test_frame_error();
        bus.data_ready = 1'b0;
        send_frame(8'h50, ^8'h50, 1'b0, 1'b0);
        total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL ferr_pulse got=%b exp=1", frame_err); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ferr_no_ovr got=%b exp=0", overrun); end
        total++; if (bus.data_valid !== 1'b0) begin bad++; $display("FAIL ferr_no_valid got=%b exp=0", bus.data_valid); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL ferr_break got=%b exp=1", busy); end
        idle_clk();
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL ferr_one_cycle got=%b exp=0", frame_err); end
        for (int i = 0; i < 3; i++) begin
            strobe(1'b0);
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL break_hold i=%0d got=%b exp=1", i, busy); end
        end
        strobe(1'b1);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL break_exit got=%b exp=0", busy); end
        send_frame(8'h43, ^8'h43, 1'b1, 1'b0);
        total++; if (bus.data_out !== 8'h43) begin bad++; $display("FAIL after_break got=%h exp=43", bus.data_out); end
        total++; if (bus.data_valid !== 1'b1) begin bad++; $display("FAIL after_break_valid got=%b exp=1", bus.data_valid); end
        bus.data_ready = 1'b1;
        idle_clk();
    endtask

    task automatic test_back_to_back();
        bus.data_ready = 1'b0;
        send_frame(8'hA5, ^8'hA5, 1'b1, 1'b0);
        total++; if (bus.data_out !== 8'hA5) begin bad++; $display("FAIL b2b_first got=%h exp=a5", bus.data_out); end
        // Second frame starts on the very next strobe; consume coincides
        // with its stop-bit sample.
        strobe(1'b0);
        for (int i = 7; i >= 0; i--) strobe(((8'h3C >> i) & 8'h01) != 0);
`ifdef RX_PARITY_EN
        strobe(^8'h3C);
`endif
        bus.data_ready = 1'b1;
        strobe(1'b1);
        total++; if (bus.data_valid !== 1'b1) begin bad++; $display("FAIL b2b_swap_valid got=%b exp=1", bus.data_valid); end
        total++; if (bus.data_out !== 8'h3C) begin bad++; $display("FAIL b2b_swap_data got=%h exp=3c", bus.data_out); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL b2b_no_ovr got=%b exp=0", overrun); end
        idle_clk();
        total++; if (bus.data_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", bus.data_valid); end
    endtask

    task automatic test_reset_mid();
        bus.data_ready = 1'b0;
        send_frame(8'h7E, ^8'h7E, 1'b1, 1'b0);
        strobe(1'b0);
        strobe(1'b1);
        strobe(1'b1);
        rst_n = 1'b0;
        idle_clk();
        rst_n = 1'b1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        total++; if (bus.data_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b exp=0", bus.data_valid); end
        total++; if (bus.data_out !== 8'h00) begin bad++; $display("FAIL midrst_data got=%h exp=00", bus.data_out); end
        send_frame(8'h81, ^8'h81, 1'b1, 1'b0);
        total++; if (bus.data_out !== 8'h81) begin bad++; $display("FAIL midrst_next got=%h exp=81", bus.data_out); end
        bus.data_ready = 1'b1;
        idle_clk();
    endtask

`ifdef RX_PARITY_EN
    task automatic test_parity();
        bus.data_ready = 1'b1;
        // 8'h62 has three ones: parity bit 0 makes the total odd.
        send_frame(8'h62, 1'b0, 1'b1, 1'b0);
        total++; if (parity_err !== 1'b1) begin bad++; $display("FAIL par_err_pulse got=%b exp=1", parity_err); end
        total++; if (bus.data_valid !== 1'b0) begin bad++; $display("FAIL par_err_no_valid got=%b exp=0", bus.data_valid); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL par_err_no_ovr got=%b exp=0", overrun); end
        idle_clk();
        total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL par_err_one_cycle got=%b exp=0", parity_err); end
        send_frame(8'h62, 1'b1, 1'b1, 1'b0);
        total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL par_ok_no_err got=%b exp=0", parity_err); end
        total++; if (bus.data_out !== 8'h62) begin bad++; $display("FAIL par_ok_data got=%h exp=62", bus.data_out); end
        idle_clk();
        // Bad parity and bad stop: only frame_err.
        send_frame(8'h62, 1'b0, 1'b0, 1'b0);
        total++; if ({frame_err, parity_err} !== 2'b10) begin bad++; $display("FAIL par_stop_prio got=%b exp=10", {frame_err, parity_err}); end
        strobe(1'b1);
    endtask
`endif

    initial begin
        rst_n          = 1'b0;
        sin            = 1'b1;
        bit_en         = 1'b0;
        bus.data_ready = 1'b0;
        test_reset();
        test_basic_frame();
        test_bit_en_gaps();
        test_overrun();
        test_frame_error();
        test_back_to_back();
        test_reset_mid();
`ifdef RX_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
